fourier_rns_ctrl: RTL and testbench

Frame-level sequencer for the 65-bit RNS DFT engine (9 moduli, N-point, operation-coded port).
- Accepts a stream of N RNS samples over valid/ready and loads them into the engine.
- Starts the compute, waits for the engine's done flag, then drains N (re, im) result pairs over a backpressured output stream.
- Sits between the sample source/sink and the engine, so no other logic ever drives the engine's addr/operation pins.

---
 rtl/fourier_rns_pkg.sv | 25 ++
 rtl/rns_pair_fifo2.sv | 54 +++++
 rtl/fourier_rns_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fourier_rns_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fourier_rns_pkg.sv
// Shared types and operation codes for the RNS DFT frame controller and its FIFO.
package fourier_rns_pkg;

  typedef logic [64:0] rns65_t;

  localparam logic [1:0] OP_IDLE    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_COMPUTE = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  typedef enum logic [1:0] {
    CLR     = 2'b00,
    LOAD    = 2'b01,
    COMPUTE = 2'b10,
    DRAIN   = 2'b11
  } state_t;

  // One drained result: real part, imaginary part, end-of-frame marker.
  typedef struct packed {
    rns65_t re;
    rns65_t im;
    logic   last;
  } pair_t;

endpackage

// File: rtl/rns_pair_fifo2.sv
// Two-entry synchronous FIFO holding (re, im, last) result pairs; push and pop may coincide.
module rns_pair_fifo2
  import fourier_rns_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  pair_t      i_wdata,
  output pair_t      o_rdata,
  output logic       o_full,
  output logic       o_empty,
  output logic [1:0] o_count
);

  pair_t      r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // A push into a full FIFO is accepted only when the same cycle frees a slot.
  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ~r_wptr;
      end
      if (w_do_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/fourier_rns_ctrl.sv
// Frame sequencer for the RNS DFT engine: clear, load N samples, compute, drain N results.
module fourier_rns_ctrl
  import fourier_rns_pkg::*;
#(
  parameter int N       = 100,
  parameter int TIMEOUT = 65536
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [64:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [64:0]  out_re,
  output logic [64:0]  out_im,
  output logic         out_last,
  output logic         busy,
  output logic         error,
  output logic [15:0]  frame_cnt,
  output logic         eng_reset,
  output logic [31:0]  eng_addr,
  output logic [64:0]  eng_x,
  output logic [1:0]   eng_op,
  input  logic [64:0]  eng_y_re,
  input  logic [64:0]  eng_y_im,
  input  logic         eng_done
);

  localparam int IW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_rd_idx;
  logic [IW-1:0]   r_rsp_idx;
  logic [TW-1:0]   r_timer;
  logic            r_inflight;
  logic            r_error;
  logic [15:0]     r_frame_cnt;

  logic            w_issue;
  logic            w_pop;
  logic            w_pop_last;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [1:0]      w_fifo_count;
  pair_t           w_fifo_wdata;
  pair_t           w_fifo_rdata;

  assign w_fifo_wdata.re   = eng_y_re;
  assign w_fifo_wdata.im   = eng_y_im;
  assign w_fifo_wdata.last = (r_rsp_idx == IW'(N - 1));

  rns_pair_fifo2 u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_wdata (w_fifo_wdata),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Reads are throttled so that queued plus outstanding results never exceed the FIFO depth.
  assign w_issue = (r_state == DRAIN) && (r_rd_idx < IW'(N)) && !w_fifo_full &&
                   (({1'b0, w_fifo_count} + {2'b00, r_inflight}) < 3'd2);

  assign out_valid  = !w_fifo_empty;
  assign out_re     = w_fifo_rdata.re;
  assign out_im     = w_fifo_rdata.im;
  assign out_last   = !w_fifo_empty && w_fifo_rdata.last;
  assign w_pop      = out_valid && out_ready;
  assign w_pop_last = w_pop && w_fifo_rdata.last;

  assign in_ready  = (r_state == LOAD);
  assign busy      = !((r_state == LOAD) && (r_idx == IW'(0)));
  assign eng_reset = (r_state == CLR);
  assign error     = r_error;
  assign frame_cnt = r_frame_cnt;

  // Engine pin drive; write and read are only ever issued outside CLR, so never under engine reset.
  always_comb begin
    eng_op   = OP_IDLE;
    eng_addr = 32'd0;
    eng_x    = 65'd0;
    case (r_state)
      LOAD: begin
        if (in_valid) begin
          eng_op   = OP_WRITE;
          eng_addr = 32'(r_idx);
          eng_x    = in_data;
        end else begin
          eng_op   = OP_IDLE;
        end
      end
      COMPUTE: begin
        eng_op = OP_COMPUTE;
      end
      DRAIN: begin
        if (w_issue) begin
          eng_op   = OP_READ;
          eng_addr = 32'(r_rd_idx);
        end else begin
          eng_op   = OP_IDLE;
        end
      end
      default: begin
        eng_op = OP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= CLR;
      r_idx       <= '0;
      r_rd_idx    <= '0;
      r_rsp_idx   <= '0;
      r_timer     <= '0;
      r_inflight  <= 1'b0;
      r_error     <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      case (r_state)
        CLR: begin
          r_state    <= LOAD;
          r_idx      <= '0;
          r_inflight <= 1'b0;
        end
        LOAD: begin
          if (in_valid) begin
            if (r_idx == IW'(N - 1)) begin
              r_state <= COMPUTE;
              r_idx   <= '0;
              r_timer <= '0;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        COMPUTE: begin
          r_timer <= r_timer + TW'(1);
          if (eng_done) begin
            r_state    <= DRAIN;
            r_rd_idx   <= '0;
            r_rsp_idx  <= '0;
            r_inflight <= 1'b0;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            // The frame is abandoned; CLR resets the engine before the next LOAD.
            r_error <= 1'b1;
            r_state <= CLR;
          end
        end
        DRAIN: begin
          r_inflight <= w_issue;
          if (w_issue) begin
            r_rd_idx <= r_rd_idx + IW'(1);
          end
          if (r_inflight) begin
            r_rsp_idx <= r_rsp_idx + IW'(1);
          end
          if (w_pop_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= CLR;
          end
        end
        default: begin
          r_state <= CLR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fourier_rns_ctrl.sv
// Self-checking bench: behavioural engine stub, scoreboard of expected results, table of frame scenarios.
module tb_fourier_rns_ctrl;
  import fourier_rns_pkg::*;

  localparam int N        = 100;
  localparam int TIMEOUT  = 300;
  localparam int DONE_LAT = 20;
  localparam logic [64:0] K_RE = 65'h1_0F0F_1234_5678_9ABC;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [64:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [64:0] out_re;
  logic [64:0] out_im;
  logic        out_last;
  logic        busy;
  logic        error;
  logic [15:0] frame_cnt;
  logic        eng_reset;
  logic [31:0] eng_addr;
  logic [64:0] eng_x;
  logic [1:0]  eng_op;
  logic [64:0] eng_y_re;
  logic [64:0] eng_y_im;
  logic        eng_done;

  fourier_rns_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy), .error(error), .frame_cnt(frame_cnt),
    .eng_reset(eng_reset), .eng_addr(eng_addr), .eng_x(eng_x), .eng_op(eng_op),
    .eng_y_re(eng_y_re), .eng_y_im(eng_y_im), .eng_done(eng_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [64:0] im_of(input logic [64:0] s, input int k);
    return {s[63:0], s[64]} + 65'(k);
  endfunction

  // Engine stub: memory, fixed compute latency (or never done), one-cycle registered read.
  logic [64:0] eng_mem [N];
  int          ccnt;
  logic        stuck_done;
  always @(posedge clk) begin
    if (eng_reset) begin
      for (int i = 0; i < N; i++) eng_mem[i] <= 65'd0;
      eng_done <= 1'b0;
      ccnt     <= 0;
    end else begin
      if (eng_op == OP_WRITE && eng_addr < N) eng_mem[eng_addr] <= eng_x;
      if (eng_op == OP_COMPUTE) begin
        ccnt <= ccnt + 1;
        if (ccnt == DONE_LAT && !stuck_done) eng_done <= 1'b1;
      end
      if (eng_op == OP_READ && eng_addr < N) begin
        eng_y_re <= eng_mem[eng_addr] ^ K_RE;
        eng_y_im <= im_of(eng_mem[eng_addr], int'(eng_addr));
      end
    end
  end

  typedef struct packed {
    logic [64:0] re;
    logic [64:0] im;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   wr_idx = 0, rd_idx = 0, pop_idx = 0, cmp_cyc = 0, rst_run = 0;
  int   last_wr = 0, last_rd = 0, last_pop = 0, last_cmp = 0, last_left = 0;
  bit   prev_rst = 1'b0, prev_rdy = 1'b0;

  // Monitor and scoreboard; inputs change just after posedge, so everything is stable here.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (eng_reset) begin
        if (!prev_rst) begin
          last_wr = wr_idx; last_rd = rd_idx; last_pop = pop_idx;
          last_cmp = cmp_cyc; last_left = exp_q.size();
        end
        rst_run++;
        wr_idx = 0; rd_idx = 0; pop_idx = 0; cmp_cyc = 0;
        exp_q.delete();
      end
      if (in_ready && !prev_rdy) begin
        check("eng_reset_pulses_before_load", 65'(rst_run), 65'd1);
        rst_run = 0;
      end
      if (eng_op == OP_WRITE || eng_op == OP_READ) check("access_under_eng_reset", 65'(eng_reset), 65'd0);
      if (in_valid && in_ready) begin
        check("write_op", 65'(eng_op), 65'(OP_WRITE));
        check("write_addr", 65'(eng_addr), 65'(wr_idx));
        check("write_data", eng_x, in_data);
        e.re = in_data ^ K_RE;
        e.im = im_of(in_data, wr_idx);
        e.last = (wr_idx == N - 1);
        exp_q.push_back(e);
        wr_idx++;
      end else begin
        check("no_write_without_handshake", 65'(eng_op == OP_WRITE), 65'd0);
      end
      if (eng_op == OP_COMPUTE) cmp_cyc++;
      if (eng_op == OP_READ) begin
        check("read_addr", 65'(eng_addr), 65'(rd_idx));
        rd_idx++;
      end
      if (out_valid && out_ready) begin
        check("pop_has_expected", 65'(exp_q.size() != 0), 65'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_re", out_re, e.re);
          check("out_im", out_im, e.im);
          check("out_last", 65'(out_last), 65'(e.last));
        end
        pop_idx++;
      end
      check("fifo_occupancy_le_2", 65'((rd_idx - pop_idx) <= 2), 65'd1);
      prev_rst = eng_reset;
      prev_rdy = in_ready;
    end
  end

  typedef struct {
    int pat;
    int vprob;
    int rdy_mode;
    bit stuck;
    bit exp_err;
    int exp_fc;
  } frame_vec_t;

  function automatic logic [64:0] sample_of(input int pat, input int k);
    logic [64:0] s;
    if (pat == 0) s = (k == 0) ? 65'd1 : 65'd0;
    else s = {1'($urandom_range(1)), $urandom, $urandom};
    return s;
  endfunction

  task automatic run_frame(input frame_vec_t v, input int abort_at);
    int n;
    stuck_done = v.stuck;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("reach_load", 65'(in_ready), 65'd1);
    if (!in_ready) return;
    check("busy_idle_load", 65'(busy), 65'd0);
    for (int k = 0; k < N; k++) begin
      while ($urandom_range(99) >= v.vprob) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = sample_of(v.pat, k);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (k == 0) check("busy_after_first_sample", 65'(busy), 65'd1);
    end
    n = 0;
    while (n < TIMEOUT + 3000) begin
      @(posedge clk); #1;
      n++;
      if (in_ready) break;
      if (abort_at >= 0 && pop_idx == abort_at) begin
        in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        check("abort_out_valid", 65'(out_valid), 65'd0);
        check("abort_eng_reset", 65'(eng_reset), 65'd1);
        check("abort_in_ready", 65'(in_ready), 65'd0);
        check("abort_busy", 65'(busy), 65'd1);
        check("abort_error", 65'(error), 65'd0);
        check("abort_frame_cnt", 65'(frame_cnt), 65'd0);
        reset = 1'b0;
        return;
      end
      case (v.rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((n % 4) == 0) || ((n % 4) == 3);
        default: out_ready = 1'($urandom_range(1));
      endcase
      in_valid = 1'($urandom_range(1));
      in_data  = {1'b1, $urandom, $urandom};
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("frame_returns_to_load", 65'(in_ready), 65'd1);
    check("writes_per_frame", 65'(last_wr), 65'(N));
    check("reads_per_frame", 65'(last_rd), v.stuck ? 65'd0 : 65'(N));
    check("results_per_frame", 65'(last_pop), v.stuck ? 65'd0 : 65'(N));
    check("unread_expected", 65'(last_left), v.stuck ? 65'(N) : 65'd0);
    check("compute_cycles", 65'(last_cmp), v.stuck ? 65'(TIMEOUT) : 65'(DONE_LAT + 2));
    check("error_flag", 65'(error), 65'(v.exp_err));
    check("frame_cnt", 65'(frame_cnt), 65'(v.exp_fc));
  endtask

  frame_vec_t vecs [5];
  frame_vec_t fv;

  initial begin
    vecs[0] = '{pat: 0, vprob: 100, rdy_mode: 0, stuck: 1'b0, exp_err: 1'b0, exp_fc: 1};
    vecs[1] = '{pat: 1, vprob: 50,  rdy_mode: 1, stuck: 1'b0, exp_err: 1'b0, exp_fc: 2};
    vecs[2] = '{pat: 1, vprob: 70,  rdy_mode: 2, stuck: 1'b0, exp_err: 1'b0, exp_fc: 3};
    vecs[3] = '{pat: 1, vprob: 100, rdy_mode: 0, stuck: 1'b1, exp_err: 1'b1, exp_fc: 3};
    vecs[4] = '{pat: 1, vprob: 100, rdy_mode: 0, stuck: 1'b0, exp_err: 1'b1, exp_fc: 4};

    reset = 1'b1; in_valid = 1'b0; in_data = 65'd0; out_ready = 1'b0; stuck_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 65'(in_ready), 65'd0);
    check("rst_out_valid", 65'(out_valid), 65'd0);
    check("rst_out_last", 65'(out_last), 65'd0);
    check("rst_busy", 65'(busy), 65'd1);
    check("rst_error", 65'(error), 65'd0);
    check("rst_frame_cnt", 65'(frame_cnt), 65'd0);
    check("rst_eng_op", 65'(eng_op), 65'd0);
    check("rst_eng_addr", 65'(eng_addr), 65'd0);
    check("rst_eng_x", eng_x, 65'd0);
    check("rst_eng_reset", 65'(eng_reset), 65'd1);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(vecs[i], -1);

    fv = '{pat: 1, vprob: 100, rdy_mode: 0, stuck: 1'b0, exp_err: 1'b0, exp_fc: 0};
    run_frame(fv, 37);
    fv = '{pat: 0, vprob: 80, rdy_mode: 1, stuck: 1'b0, exp_err: 1'b0, exp_fc: 1};
    run_frame(fv, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
